// File: rtl/text_mode_pkg.sv
// Shared constants and stage bundles for the text-mode glyph renderer.
// Geometry of the 8x16 font and the fixed pipeline depth live here.
package text_mode_pkg;

    localparam int GLYPH_W          = 8;
    localparam int GLYPH_H          = 16;
    localparam int LAT              = 5;
    localparam int FONT_AW          = 11;
    localparam int CHAR_AW          = 12;
    localparam int CURSOR_FIRST_ROW = 14;

    typedef struct packed {
        logic       de;
        logic [2:0] xb;
        logic       in_area;
        logic       hit;
    } pix_meta_t;

    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
    } sync_t;

endpackage

// File: rtl/sideband_delay.sv
// Fixed-depth shift-register delay line with synchronous reset.
// Keeps per-pixel sidebands aligned with the memory read pipeline.
module sideband_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_sr [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_sr[i] <= '0;
            end
        end else begin
            r_sr[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) begin
                r_sr[i] <= r_sr[i-1];
            end
        end
    end

    assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/text_glyph_renderer.sv
// Text-mode pixel generator: text RAM -> font pROM -> serialised glyph bits,
// with inverse-video attribute and a blinking underline cursor.
module text_glyph_renderer
    import text_mode_pkg::*;
#(
    parameter int          COLS         = 80,
    parameter int          ROWS         = 30,
    parameter int          BLINK_FRAMES = 30,
    parameter logic [23:0] FG_RGB       = 24'hFFFFFF,
    parameter logic [23:0] BG_RGB       = 24'h000000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [10:0]          x_in,
    input  logic [9:0]           y_in,
    input  logic                 de_in,
    input  logic                 hs_in,
    input  logic                 vs_in,
    input  logic                 cursor_en,
    input  logic [6:0]           cursor_col,
    input  logic [4:0]           cursor_row,
    output logic [CHAR_AW-1:0]   char_addr,
    input  logic [7:0]           char_data,
    output logic [FONT_AW-1:0]   font_ad,
    output logic                 font_ce,
    output logic                 font_oce,
    output logic                 font_reset,
    input  logic [7:0]           font_dout,
    output logic [23:0]          rgb_out,
    output logic                 de_out,
    output logic                 hs_out,
    output logic                 vs_out
);

    localparam int XS    = $clog2(GLYPH_W);
    localparam int YS    = $clog2(GLYPH_H);
    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(BLINK_FRAMES - 1);
    localparam logic [7:0]         COLS_C    = 8'(COLS);
    localparam logic [5:0]         ROWS_C    = 6'(ROWS);
    localparam logic [CHAR_AW-1:0] COLS_A    = CHAR_AW'(COLS);
    localparam logic [3:0]         FIRST_ROW = 4'(CURSOR_FIRST_ROW);

    generate
        if (COLS * ROWS > (1 << CHAR_AW)) begin : g_size_chk
            $error("COLS*ROWS does not fit the text RAM address");
        end
    endgenerate

    logic [7:0]         w_col;
    logic [5:0]         w_row;
    logic               w_in_area;
    logic               w_hit;
    logic [CHAR_AW-1:0] w_addr;
    logic               w_vs_rise;
    logic [3:0]         w_yrow_d;
    logic               w_pix;
    logic [23:0]        w_rgb_nxt;
    pix_meta_t          w_meta_in;
    pix_meta_t          w_meta_d;
    sync_t              w_sync_in;
    sync_t              w_sync_d;

    logic               r_vs_prev;
    logic               r_blink_on;
    logic [CNT_W-1:0]   r_frame_cnt;
    logic [CHAR_AW-1:0] r_char_addr;
    logic [FONT_AW-1:0] r_font_ad;
    logic [1:0]         r_inv;
    logic [23:0]        r_rgb;

    assign w_col     = x_in[10:XS];
    assign w_row     = y_in[9:YS];
    assign w_in_area = (w_col < COLS_C) && (w_row < ROWS_C);
    assign w_addr    = CHAR_AW'(w_row) * COLS_A + CHAR_AW'(w_col);

    assign w_hit = cursor_en && r_blink_on
                && (w_col == {1'b0, cursor_col})
                && (w_row == {1'b0, cursor_row})
                && (y_in[3:0] >= FIRST_ROW);

    // Blink phase advances on vs_in 0->1 whatever the sync polarity.
    assign w_vs_rise = vs_in && !r_vs_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vs_prev   <= 1'b0;
            r_blink_on  <= 1'b1;
            r_frame_cnt <= '0;
        end else begin
            r_vs_prev <= vs_in;
            if (w_vs_rise) begin
                if (r_frame_cnt == CNT_LAST) begin
                    r_frame_cnt <= '0;
                    r_blink_on  <= ~r_blink_on;
                end else begin
                    r_frame_cnt <= r_frame_cnt + 1'b1;
                end
            end
        end
    end

    assign w_meta_in.de      = de_in;
    assign w_meta_in.xb      = x_in[2:0];
    assign w_meta_in.in_area = w_in_area;
    assign w_meta_in.hit     = w_hit;

    assign w_sync_in.de = de_in;
    assign w_sync_in.hs = hs_in;
    assign w_sync_in.vs = vs_in;

    sideband_delay #(
        .WIDTH ($bits(pix_meta_t)),
        .DEPTH (LAT - 1)
    ) u_meta_dly (
        .clk   (clk),
        .reset (reset),
        .i_d   (w_meta_in),
        .o_q   (w_meta_d)
    );

    sideband_delay #(
        .WIDTH (4),
        .DEPTH (2)
    ) u_yrow_dly (
        .clk   (clk),
        .reset (reset),
        .i_d   (y_in[3:0]),
        .o_q   (w_yrow_d)
    );

    sideband_delay #(
        .WIDTH ($bits(sync_t)),
        .DEPTH (LAT)
    ) u_sync_dly (
        .clk   (clk),
        .reset (reset),
        .i_d   (w_sync_in),
        .o_q   (w_sync_d)
    );

    // Cursor XOR on top of the inverse attribute: cursor on inverse shows normal.
    assign w_pix     = w_meta_d.in_area
                    && (font_dout[~w_meta_d.xb] ^ r_inv[1] ^ w_meta_d.hit);
    assign w_rgb_nxt = w_meta_d.de ? (w_pix ? FG_RGB : BG_RGB) : 24'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_char_addr <= '0;
            r_font_ad   <= '0;
            r_inv       <= '0;
            r_rgb       <= '0;
        end else begin
            r_char_addr <= w_in_area ? w_addr : '0;
            r_font_ad   <= {char_data[6:0], w_yrow_d};
            r_inv       <= {r_inv[0], char_data[7]};
            r_rgb       <= w_rgb_nxt;
        end
    end

    assign char_addr  = r_char_addr;
    assign font_ad    = r_font_ad;
    assign font_ce    = ~reset;
    assign font_oce   = ~reset;
    assign font_reset = reset;
    assign rgb_out    = r_rgb;
    assign de_out     = w_sync_d.de;
    assign hs_out     = w_sync_d.hs;
    assign vs_out     = w_sync_d.vs;

endmodule

// File: tb/tb_text_glyph_renderer.sv
// Bench for text_glyph_renderer: text RAM and font pROM models plus a
// pixel-level reference computed from character/glyph geometry.
module tb_text_glyph_renderer;

    localparam logic [23:0] FG = 24'hF0E0D0;
    localparam logic [23:0] BG = 24'h102030;
    localparam int NCOL  = 80;
    localparam int NROW  = 30;
    localparam int BLINK = 30;

    typedef struct packed {
        logic [10:0] x;
        logic [9:0]  y;
        logic        de;
        logic        hs;
        logic        vs;
        logic        rst;
    } stim_t;

    typedef struct packed {
        logic [23:0] rgb;
        logic [2:0]  sb;
        logic [10:0] fad;
        logic        chk_fad;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] x_in;
    logic [9:0]  y_in;
    logic        de_in, hs_in, vs_in;
    logic        cursor_en;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic [11:0] char_addr;
    logic [7:0]  char_data;
    logic [10:0] font_ad;
    logic        font_ce, font_oce, font_reset;
    logic [7:0]  font_dout;
    logic [23:0] rgb_out;
    logic        de_out, hs_out, vs_out;

    logic [7:0] text_mem [4096];
    logic [7:0] font_mem [2048];

    int   errors = 0;
    int   checks = 0;
    int   edges  = 0;
    bit   prev_vs = 0;
    exp_t q[$];
    exp_t e_out;
    logic [11:0] e_addr;
    logic [10:0] e_fad;
    bit   e_fad_ok;

    text_glyph_renderer #(
        .COLS         (NCOL),
        .ROWS         (NROW),
        .BLINK_FRAMES (BLINK),
        .FG_RGB       (FG),
        .BG_RGB       (BG)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .x_in       (x_in),
        .y_in       (y_in),
        .de_in      (de_in),
        .hs_in      (hs_in),
        .vs_in      (vs_in),
        .cursor_en  (cursor_en),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .char_addr  (char_addr),
        .char_data  (char_data),
        .font_ad    (font_ad),
        .font_ce    (font_ce),
        .font_oce   (font_oce),
        .font_reset (font_reset),
        .font_dout  (font_dout),
        .rgb_out    (rgb_out),
        .de_out     (de_out),
        .hs_out     (hs_out),
        .vs_out     (vs_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        char_data <= text_mem[char_addr];
        font_dout <= font_mem[font_ad];
    end

    function automatic stim_t mk(input int x, input int y, input logic de,
                                 input logic hs, input logic vs, input logic rst);
        stim_t s;
        s.x = 11'(x); s.y = 10'(y);
        s.de = de; s.hs = hs; s.vs = vs; s.rst = rst;
        return s;
    endfunction

    // Drive one pixel, predict its output, advance one clock.
    task automatic step(input stim_t s);
        exp_t e;
        int col, row, gr, xi, addr;
        bit in_area, blink_on, hit, bv;
        logic [7:0] c, g;
        xi = int'(s.x);
        col = xi / 8;
        row = int'(s.y) / 16;
        gr  = int'(s.y) % 16;
        in_area = (col < NCOL) && (row < NROW);
        addr = in_area ? row * NCOL + col : 0;
        c = text_mem[addr];
        e.fad = {c[6:0], 4'(gr)};
        g = font_mem[e.fad];
        blink_on = ((edges / BLINK) % 2) == 0;
        hit = cursor_en && blink_on && col == int'(cursor_col)
           && row == int'(cursor_row) && gr >= 14;
        bv = in_area && (g[7 - (xi % 8)] ^ c[7] ^ hit);
        e.rgb = s.de ? (bv ? FG : BG) : 24'h0;
        e.sb = {s.de, s.hs, s.vs};
        e.chk_fad = 1'b1;
        x_in = s.x; y_in = s.y;
        de_in = s.de; hs_in = s.hs; vs_in = s.vs;
        reset = s.rst;
        if (s.rst) begin
            edges = 0;
            prev_vs = 0;
        end else begin
            if (s.vs && !prev_vs) edges++;
            prev_vs = s.vs;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (s.rst) begin
            q.delete();
            repeat (4) q.push_back('0);
            e_out = '0;
            e_addr = '0;
            e_fad = '0;
            e_fad_ok = 1;
        end else begin
            e_out = q.pop_front();
            e_addr = 12'(addr);
            e_fad_ok = q[1].chk_fad;
            e_fad = q[1].fad;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(mk($urandom_range(0, 639), $urandom_range(0, 479), 1'b1, 1'b1, 1'b1, i < 2));
            if (rgb_out !== e_out.rgb || {de_out, hs_out, vs_out} !== e_out.sb) begin
                errors++;
                $display("FAIL reset_out i=%0d got=%h/%b exp=%h/%b", i,
                         rgb_out, {de_out, hs_out, vs_out}, e_out.rgb, e_out.sb);
            end
            checks++;
            if ({font_ce, font_oce, font_reset} !== ((i < 2) ? 3'b001 : 3'b110)) begin
                errors++;
                $display("FAIL reset_font_ctl i=%0d got=%b", i, {font_ce, font_oce, font_reset});
            end
            checks++;
            if (i < 2 && (char_addr !== 12'h0 || font_ad !== 11'h0)) begin
                errors++;
                $display("FAIL reset_addr got=%h/%h exp=0/0", char_addr, font_ad);
            end
            if (i < 2) checks++;
        end
    endtask

    task automatic test_glyph();
        stim_t s[$];
        for (int x = 0; x < 8; x++) s.push_back(mk(x, 2, 1'b1, x[0], 1'b0, 1'b0));
        repeat (5) s.push_back(mk(700, 2, 1'b0, 1'b1, 1'b0, 1'b0));
        foreach (s[i]) begin
            step(s[i]);
            if (rgb_out !== e_out.rgb) begin
                errors++;
                $display("FAIL glyph_rgb i=%0d got=%h exp=%h", i, rgb_out, e_out.rgb);
            end
            checks++;
            if ({de_out, hs_out, vs_out} !== e_out.sb) begin
                errors++;
                $display("FAIL glyph_sync i=%0d got=%b exp=%b", i, {de_out, hs_out, vs_out}, e_out.sb);
            end
            checks++;
            if (char_addr !== e_addr) begin
                errors++;
                $display("FAIL glyph_addr i=%0d got=%h exp=%h", i, char_addr, e_addr);
            end
            checks++;
            if (e_fad_ok && font_ad !== e_fad) begin
                errors++;
                $display("FAIL glyph_fad i=%0d got=%h exp=%h", i, font_ad, e_fad);
            end
            if (e_fad_ok) checks++;
            if (i == 2) begin
                if (font_ad !== 11'h412) begin
                    errors++;
                    $display("FAIL glyph_fad_A got=%h exp=412", font_ad);
                end
                checks++;
            end
        end
    endtask

    task automatic test_out_of_area();
        stim_t s[$];
        s.push_back(mk(645, 10, 1'b1, 1'b0, 1'b1, 1'b0));
        s.push_back(mk(639, 479, 1'b1, 1'b1, 1'b0, 1'b0));
        s.push_back(mk(640, 479, 1'b1, 1'b0, 1'b0, 1'b0));
        s.push_back(mk(5, 480, 1'b1, 1'b1, 1'b1, 1'b0));
        s.push_back(mk(1023, 1000, 1'b1, 1'b0, 1'b1, 1'b0));
        s.push_back(mk(12, 3, 1'b0, 1'b1, 1'b0, 1'b0));
        s.push_back(mk(645, 10, 1'b0, 1'b0, 1'b0, 1'b0));
        repeat (5) s.push_back(mk(700, 0, 1'b0, 1'b0, 1'b0, 1'b0));
        foreach (s[i]) begin
            step(s[i]);
            if (rgb_out !== e_out.rgb) begin
                errors++;
                $display("FAIL area_rgb i=%0d got=%h exp=%h", i, rgb_out, e_out.rgb);
            end
            checks++;
            if ({de_out, hs_out, vs_out} !== e_out.sb) begin
                errors++;
                $display("FAIL area_sync i=%0d got=%b exp=%b", i, {de_out, hs_out, vs_out}, e_out.sb);
            end
            checks++;
            if (char_addr !== e_addr) begin
                errors++;
                $display("FAIL area_addr i=%0d got=%h exp=%h", i, char_addr, e_addr);
            end
            checks++;
        end
    endtask

    task automatic test_inverse();
        stim_t s[$];
        for (int x = 8; x < 16; x++) s.push_back(mk(x, 2, 1'b1, 1'b0, 1'b0, 1'b0));
        repeat (5) s.push_back(mk(700, 2, 1'b0, 1'b0, 1'b0, 1'b0));
        foreach (s[i]) begin
            step(s[i]);
            if (rgb_out !== e_out.rgb) begin
                errors++;
                $display("FAIL inverse_rgb i=%0d got=%h exp=%h", i, rgb_out, e_out.rgb);
            end
            checks++;
            if (e_fad_ok && font_ad !== e_fad) begin
                errors++;
                $display("FAIL inverse_fad i=%0d got=%h exp=%h", i, font_ad, e_fad);
            end
            if (e_fad_ok) checks++;
        end
    endtask

    task automatic test_cursor();
        stim_t s[$];
        int ys[3] = '{46, 47, 45};
        cursor_en = 1'b1; cursor_col = 7'd3; cursor_row = 5'd2;
        foreach (ys[k])
            for (int x = 16; x < 40; x++) s.push_back(mk(x, ys[k], 1'b1, 1'b0, 1'b0, 1'b0));
        repeat (5) s.push_back(mk(700, 0, 1'b0, 1'b0, 1'b0, 1'b0));
        foreach (s[i]) begin
            step(s[i]);
            if (rgb_out !== e_out.rgb) begin
                errors++;
                $display("FAIL cursor_rgb i=%0d got=%h exp=%h", i, rgb_out, e_out.rgb);
            end
            checks++;
        end
    endtask

    task automatic test_reset_midline();
        stim_t s[$];
        for (int x = 20; x < 26; x++) s.push_back(mk(x, 46, 1'b1, 1'b1, 1'b0, 1'b0));
        s.push_back(mk(26, 46, 1'b1, 1'b1, 1'b1, 1'b1));
        s.push_back(mk(27, 46, 1'b1, 1'b1, 1'b1, 1'b1));
        for (int x = 24; x < 32; x++) s.push_back(mk(x, 46, 1'b1, 1'b0, 1'b0, 1'b0));
        repeat (5) s.push_back(mk(700, 0, 1'b0, 1'b0, 1'b0, 1'b0));
        foreach (s[i]) begin
            step(s[i]);
            if (rgb_out !== e_out.rgb) begin
                errors++;
                $display("FAIL midreset_rgb i=%0d got=%h exp=%h", i, rgb_out, e_out.rgb);
            end
            checks++;
            if ({de_out, hs_out, vs_out} !== e_out.sb) begin
                errors++;
                $display("FAIL midreset_sync i=%0d got=%b exp=%b", i, {de_out, hs_out, vs_out}, e_out.sb);
            end
            checks++;
            if (char_addr !== e_addr) begin
                errors++;
                $display("FAIL midreset_addr i=%0d got=%h exp=%h", i, char_addr, e_addr);
            end
            checks++;
        end
    endtask

    task automatic test_blink();
        stim_t s[$];
        int plan[4] = '{29, 1, 30, 0};
        foreach (plan[p]) begin
            for (int k = 0; k < plan[p]; k++) begin
                s.push_back(mk(700, 0, 1'b0, 1'b0, 1'b0, 1'b0));
                s.push_back(mk(700, 0, 1'b0, 1'b0, 1'b1, 1'b0));
            end
            if (p == 3) repeat (40) s.push_back(mk(700, 0, 1'b0, 1'b0, 1'b1, 1'b0));
            for (int x = 24; x < 32; x++) s.push_back(mk(x, 46, 1'b1, 1'b0, 1'b0, 1'b0));
            repeat (5) s.push_back(mk(700, 0, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        foreach (s[i]) begin
            step(s[i]);
            if (rgb_out !== e_out.rgb) begin
                errors++;
                $display("FAIL blink_rgb i=%0d got=%h exp=%h", i, rgb_out, e_out.rgb);
            end
            checks++;
            if ({de_out, hs_out, vs_out} !== e_out.sb) begin
                errors++;
                $display("FAIL blink_sync i=%0d got=%b exp=%b", i, {de_out, hs_out, vs_out}, e_out.sb);
            end
            checks++;
        end
    endtask

    task automatic test_random();
        logic vs = 1'b0;
        int x, y;
        for (int i = 0; i < 800; i++) begin
            if (i % 80 == 0) begin
                cursor_en  = ($urandom_range(0, 3) != 0);
                cursor_col = 7'($urandom_range(0, NCOL - 1));
                cursor_row = 5'($urandom_range(0, NROW - 1));
            end
            x = ($urandom_range(0, 3) == 0) ? int'(cursor_col) * 8 + $urandom_range(0, 7)
                                            : $urandom_range(0, 700);
            y = ($urandom_range(0, 3) == 0) ? int'(cursor_row) * 16 + $urandom_range(12, 15)
                                            : $urandom_range(0, 520);
            if ($urandom_range(0, 3) == 0) vs = ~vs;
            step(mk(x, y, ($urandom_range(0, 5) != 0), 1'($urandom), vs, 1'b0));
            if (rgb_out !== e_out.rgb) begin
                errors++;
                $display("FAIL rand_rgb i=%0d got=%h exp=%h", i, rgb_out, e_out.rgb);
            end
            checks++;
            if ({de_out, hs_out, vs_out} !== e_out.sb) begin
                errors++;
                $display("FAIL rand_sync i=%0d got=%b exp=%b", i, {de_out, hs_out, vs_out}, e_out.sb);
            end
            checks++;
            if (char_addr !== e_addr) begin
                errors++;
                $display("FAIL rand_addr i=%0d got=%h exp=%h", i, char_addr, e_addr);
            end
            checks++;
            if (e_fad_ok && font_ad !== e_fad) begin
                errors++;
                $display("FAIL rand_fad i=%0d got=%h exp=%h", i, font_ad, e_fad);
            end
            if (e_fad_ok) checks++;
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) text_mem[i] = 8'($urandom);
        for (int i = 0; i < 2048; i++) font_mem[i] = 8'($urandom);
        text_mem[0] = 8'h41;
        text_mem[1] = 8'hC1;
        font_mem[11'h412] = 8'h3C;
        cursor_en = 1'b0; cursor_col = '0; cursor_row = '0;
        reset = 1'b1; x_in = '0; y_in = '0;
        de_in = 1'b0; hs_in = 1'b0; vs_in = 1'b0;
        #1;
        test_reset();
        test_glyph();
        test_out_of_area();
        test_inverse();
        test_cursor();
        test_reset_midline();
        test_blink();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
